// File: rtl/if_stage_if.sv
// Instruction-memory fetch bus: valid/ready request channel plus a valid-only response channel.
// The fetch stage drives requests (master); instruction memory answers them (slave).
interface if_stage_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic [31:0] resp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  resp_valid,
        input  resp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output resp_valid,
        output resp_data
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, keeps one fetch in flight, fills the IF/ID register,
// parks a response that lands during a decode stall, and kills in-flight fetches on EX redirect.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               rst_n,
    if_stage_if.master         imem,
    input  logic               ID_stall,
    input  logic               EX_redirect,
    input  logic [31:0]        EX_redirect_pc,
    output logic [31:0]        IF_ID_instruction,
    output logic [31:0]        IF_ID_pc,
    output logic               IF_ID_valid
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_DROP = 3'd3,
        ST_HOLD = 3'd4
    } state_e;

    state_e      state_r;
    logic [31:0] pc_r;
    logic [31:0] inflight_pc_r;
    logic [31:0] hold_instr_r;
    logic [31:0] hold_pc_r;
    logic        hold_valid_r;
    logic        req_valid_r;
    logic [31:0] if_id_instr_r;
    logic [31:0] if_id_pc_r;
    logic        if_id_valid_r;

    logic [31:0] redirect_pc_s;
    logic [31:0] pc_next_s;

    assign redirect_pc_s = EX_redirect_pc & ~32'h0000_0003;
    assign pc_next_s     = pc_r + 32'd4;

    assign imem.req_valid    = req_valid_r;
    assign imem.req_addr     = pc_r;
    assign IF_ID_instruction = if_id_instr_r;
    assign IF_ID_pc          = if_id_pc_r;
    assign IF_ID_valid       = if_id_valid_r;

    // Fetch FSM; req_valid_r is loaded alongside the next state so the request stays Moore.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            pc_r          <= RESET_PC;
            inflight_pc_r <= RESET_PC;
            hold_instr_r  <= NOP_INSTR;
            hold_pc_r     <= 32'h0000_0000;
            hold_valid_r  <= 1'b0;
            req_valid_r   <= 1'b0;
            if_id_instr_r <= NOP_INSTR;
            if_id_pc_r    <= 32'h0000_0000;
            if_id_valid_r <= 1'b0;
        end else if (EX_redirect) begin
            pc_r          <= redirect_pc_s;
            hold_valid_r  <= 1'b0;
            if_id_instr_r <= NOP_INSTR;
            if_id_pc_r    <= 32'h0000_0000;
            if_id_valid_r <= 1'b0;
            // A request already accepted (or still unanswered) must have its response swallowed.
            case (state_r)
                ST_REQ: begin
                    state_r     <= imem.req_ready ? ST_DROP : ST_REQ;
                    req_valid_r <= ~imem.req_ready;
                end
                ST_WAIT, ST_DROP: begin
                    state_r     <= imem.resp_valid ? ST_REQ : ST_DROP;
                    req_valid_r <= imem.resp_valid;
                end
                default: begin
                    state_r     <= ST_REQ;
                    req_valid_r <= 1'b1;
                end
            endcase
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r     <= ST_REQ;
                    req_valid_r <= 1'b1;
                end
                ST_REQ: begin
                    if (imem.req_ready) begin
                        state_r       <= ST_WAIT;
                        req_valid_r   <= 1'b0;
                        inflight_pc_r <= pc_r;
                    end
                end
                ST_WAIT: begin
                    if (imem.resp_valid) begin
                        if (!ID_stall || !if_id_valid_r) begin
                            if_id_instr_r <= imem.resp_data;
                            if_id_pc_r    <= inflight_pc_r;
                            if_id_valid_r <= 1'b1;
                            pc_r          <= pc_next_s;
                            state_r       <= ST_REQ;
                            req_valid_r   <= 1'b1;
                        end else begin
                            hold_instr_r <= imem.resp_data;
                            hold_pc_r    <= inflight_pc_r;
                            hold_valid_r <= 1'b1;
                            state_r      <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!ID_stall && hold_valid_r) begin
                        if_id_instr_r <= hold_instr_r;
                        if_id_pc_r    <= hold_pc_r;
                        if_id_valid_r <= 1'b1;
                        hold_valid_r  <= 1'b0;
                        pc_r          <= pc_next_s;
                        state_r       <= ST_REQ;
                        req_valid_r   <= 1'b1;
                    end else if (!hold_valid_r) begin
                        state_r     <= ST_REQ;
                        req_valid_r <= 1'b1;
                    end
                end
                ST_DROP: begin
                    if (imem.resp_valid) begin
                        state_r     <= ST_REQ;
                        req_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    req_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed protocol scenarios followed by randomized traffic, all checked
// against a transaction-level model of the fetch/deliver address streams and a latency memory.
module tb_if_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ID_stall;
    logic        EX_redirect;
    logic [31:0] EX_redirect_pc;
    logic [31:0] IF_ID_instruction;
    logic [31:0] IF_ID_pc;
    logic        IF_ID_valid;

    if_stage_if imem();

    if_stage dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem             (imem),
        .ID_stall         (ID_stall),
        .EX_redirect      (EX_redirect),
        .EX_redirect_pc   (EX_redirect_pc),
        .IF_ID_instruction(IF_ID_instruction),
        .IF_ID_pc         (IF_ID_pc),
        .IF_ID_valid      (IF_ID_valid)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int deliveries = 0;

    // Reference model: next address to be requested, next address to be delivered to decode,
    // whether the outstanding fetch is still wanted, and whether a wanted word is parked.
    logic [31:0] fetch_pc;
    logic [31:0] deliver_pc;
    bit          live_out;
    bit          held;
    // Memory model
    bit          mem_pend;
    int          mem_rem;
    logic [31:0] mem_data;
    int          lat;

    // Per-cycle snapshot of DUT inputs/outputs before the clock edge
    logic        p_req_valid, p_ready, p_resp, p_stall, p_redir, p_v;
    logic [31:0] p_addr, p_rpc, p_i, p_pc;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic ld;
        if (mem_pend && mem_rem == 0) begin
            imem.resp_valid = 1'b1;
            imem.resp_data  = mem_data;
        end else begin
            imem.resp_valid = 1'b0;
            imem.resp_data  = $urandom();
            if (mem_pend) mem_rem--;
        end
        p_req_valid = imem.req_valid; p_addr = imem.req_addr; p_ready = imem.req_ready;
        p_resp = imem.resp_valid; p_stall = ID_stall; p_redir = EX_redirect; p_rpc = EX_redirect_pc;
        p_v = IF_ID_valid; p_i = IF_ID_instruction; p_pc = IF_ID_pc;
        ld = 1'b0;
        if (!p_redir) begin
            if (p_resp && live_out && (!p_stall || !p_v)) ld = 1'b1;
            else if (held && !p_stall) ld = 1'b1;
        end
        if (p_req_valid) begin
            chk("req_addr", p_addr, fetch_pc);
            chk("one_outstanding", 32'(mem_pend), 32'd0);
        end
        @(posedge clk);
        #1;
        if (p_redir) begin
            chk("flush_valid", 32'(IF_ID_valid), 32'd0);
            chk("flush_instr", IF_ID_instruction, NOP);
            chk("flush_pc", IF_ID_pc, 32'd0);
        end else if (ld) begin
            chk("load_valid", 32'(IF_ID_valid), 32'd1);
            chk("load_pc", IF_ID_pc, deliver_pc);
            chk("load_instr", IF_ID_instruction, word_at(deliver_pc));
            deliveries++;
        end else begin
            chk("keep_valid", 32'(IF_ID_valid), 32'(p_v));
            chk("keep_instr", IF_ID_instruction, p_i);
            chk("keep_pc", IF_ID_pc, p_pc);
        end
        if (p_resp) mem_pend = 1'b0;
        if (p_req_valid && p_ready) begin
            mem_pend = 1'b1;
            mem_rem  = lat - 1;
            mem_data = word_at(p_addr);
        end
        if (p_redir) begin
            fetch_pc   = p_rpc & ~32'h3;
            deliver_pc = p_rpc & ~32'h3;
            live_out   = 1'b0;
            held       = 1'b0;
        end else begin
            if (ld) begin deliver_pc = deliver_pc + 32'd4; held = 1'b0; end
            if (p_resp && live_out) begin live_out = 1'b0; if (!ld) held = 1'b1; end
            if (p_req_valid && p_ready) begin live_out = 1'b1; fetch_pc = fetch_pc + 32'd4; end
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input bit stale);
        rst_n = 1'b0;
        imem.req_ready = 1'b0; imem.resp_valid = 1'b0; imem.resp_data = 32'd0;
        ID_stall = 1'b0; EX_redirect = 1'b0; EX_redirect_pc = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_req_valid", 32'(imem.req_valid), 32'd0);
        chk("rst_req_addr", imem.req_addr, 32'h0000_0000);
        chk("rst_valid", 32'(IF_ID_valid), 32'd0);
        chk("rst_instr", IF_ID_instruction, NOP);
        chk("rst_pc", IF_ID_pc, 32'd0);
        fetch_pc = 32'h0000_0000; deliver_pc = 32'h0000_0000;
        live_out = 1'b0; held = 1'b0;
        mem_pend = stale; mem_rem = 0; mem_data = 32'hDEAD_BEEF;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        imem.req_ready = 1'b0; imem.resp_valid = 1'b0; imem.resp_data = 32'd0;
        ID_stall = 1'b0; EX_redirect = 1'b0; EX_redirect_pc = 32'd0;
        lat = 1;
        @(negedge clk);
        do_reset(1'b0);

        // 1-cycle memory, always ready: requests 0x0/0x4/0x8 in cycles 2/4/6
        imem.req_ready = 1'b1; lat = 1;
        tick(); chk("c1_idle", 32'(p_req_valid), 32'd0);
        tick(); chk("c2_req", 32'(p_req_valid), 32'd1); chk("c2_addr", p_addr, 32'h0);
        tick(); chk("c3_noreq", 32'(p_req_valid), 32'd0); chk("c3_pc", IF_ID_pc, 32'h0);
        tick(); chk("c4_addr", p_addr, 32'h4);
        tick(); chk("c5_pc", IF_ID_pc, 32'h4);
        tick(); chk("c6_req", 32'(p_req_valid), 32'd1); chk("c6_addr", p_addr, 32'h8);
        tick(); chk("c7_pc", IF_ID_pc, 32'h8);

        // Decode stall for 5 cycles while the 0xC response lands -> parked, no new request
        ID_stall = 1'b1;
        tick();
        tick(); chk("stall_frozen", IF_ID_pc, 32'h8);
        for (int i = 0; i < 3; i++) begin
            tick(); chk("hold_noreq", 32'(p_req_valid), 32'd0);
        end
        ID_stall = 1'b0;
        tick(); chk("release_pc", IF_ID_pc, 32'hC); chk("release_noreq", 32'(p_req_valid), 32'd0);
        lat = 3;
        tick(); chk("after_release_req", 32'(p_req_valid), 32'd1); chk("after_release_addr", p_addr, 32'h10);

        // Redirect while waiting on a 3-cycle fetch
        EX_redirect = 1'b1; EX_redirect_pc = 32'h0000_0100;
        tick(); chk("redir_wait_valid", 32'(IF_ID_valid), 32'd0);
        EX_redirect = 1'b0;
        tick(); chk("drop_noreq1", 32'(p_req_valid), 32'd0);
        lat = 1;
        tick(); chk("drop_noreq2", 32'(p_req_valid), 32'd0); chk("drop_discard", 32'(IF_ID_valid), 32'd0);
        tick(); chk("redir_req", 32'(p_req_valid), 32'd1); chk("redir_addr", p_addr, 32'h100);
        tick(); chk("redir_pc", IF_ID_pc, 32'h100);
        tick(); chk("next_addr", p_addr, 32'h104);

        // Redirect coincides with the response, then with a request handshake (unaligned target)
        EX_redirect = 1'b1; EX_redirect_pc = 32'h0000_0200;
        tick(); chk("redir_resp_valid", 32'(IF_ID_valid), 32'd0);
        EX_redirect_pc = 32'h0000_0203;
        tick(); chk("redir_hs_addr", p_addr, 32'h200); chk("redir_hs_valid", 32'(IF_ID_valid), 32'd0);
        EX_redirect = 1'b0;
        tick(); chk("hs_drop_noreq", 32'(p_req_valid), 32'd0); chk("hs_drop_valid", 32'(IF_ID_valid), 32'd0);
        tick(); chk("aligned_addr", p_addr, 32'h200);
        tick(); chk("aligned_pc", IF_ID_pc, 32'h200); chk("aligned_instr", IF_ID_instruction, word_at(32'h200));

        // Redirect with no handshake, then fetch across the top of the address space
        imem.req_ready = 1'b0; EX_redirect = 1'b1; EX_redirect_pc = 32'hFFFF_FFFC;
        tick();
        imem.req_ready = 1'b1; EX_redirect = 1'b0;
        tick(); chk("top_req", 32'(p_req_valid), 32'd1); chk("top_addr", p_addr, 32'hFFFF_FFFC);
        tick(); chk("top_pc", IF_ID_pc, 32'hFFFF_FFFC);
        lat = 3;
        tick(); chk("wrap_addr", p_addr, 32'h0000_0000);
        tick();

        // Asynchronous reset while waiting, stale response in the IDLE cycle afterwards
        #1 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(IF_ID_valid), 32'd0);
        chk("arst_pc", IF_ID_pc, 32'd0);
        chk("arst_instr", IF_ID_instruction, NOP);
        chk("arst_req", 32'(imem.req_valid), 32'd0);
        do_reset(1'b1);
        imem.req_ready = 1'b1; lat = 1;
        tick(); chk("stale_ignored", 32'(IF_ID_valid), 32'd0); chk("stale_noreq", 32'(p_req_valid), 32'd0);
        tick(); chk("post_rst_addr", p_addr, 32'h0);

        // Randomized traffic against the model
        deliveries = 0;
        for (int n = 0; n < 2000; n++) begin
            imem.req_ready = ($urandom_range(0, 3) != 0);
            lat            = $urandom_range(1, 3);
            ID_stall       = ($urandom_range(0, 9) < 3);
            EX_redirect    = ($urandom_range(0, 49) == 0);
            case ($urandom_range(0, 2))
                0:       EX_redirect_pc = $urandom();
                1:       EX_redirect_pc = 32'hFFFF_FFF0 | ($urandom() & 32'h0000_000F);
                default: EX_redirect_pc = $urandom() & 32'h0000_0FFF;
            endcase
            tick();
        end
        EX_redirect = 1'b0; ID_stall = 1'b0;
        chk("progress", 32'(deliveries > 100), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
